aes_dec_key_prep: RTL and testbench



---
 rtl/aes_dec_key_prep.sv | 172 +++++++++++++++++
 tb/tb_aes_dec_key_prep.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_dec_key_prep.sv
// AES-128 decode front end: expands the cipher key to round 10, caches it,
// and hands ciphertext + round-10 key to the decoder as a one-cycle start.
// Ports:
//   clk, reset        clock, async active-high reset
//   in_v_i            input block valid
//   in_data_i         ciphertext block
//   in_key_i          cipher key (w0 = [127:96])
//   ready_o           accepting input this cycle
//   out_v_o           start pulse to decoder
//   out_data_o        ciphertext to decoder
//   out_key_o         round-10 key to decoder
//   dec_res_v_i       decoder result-valid pulse

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(
    input logic [7:0] p,
    input logic [7:0] q
  );
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x = p;
    for (int i = 0; i < 8; i++) begin
      if (q[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // multiplicative inverse as a^254 (0 maps to 0)
  logic [7:0] x2, x3, x6, x7, x14, x15;
  logic [7:0] x30, x31, x62, x63, x126, x127;
  logic [7:0] inv;

  assign x2   = gmul(a, a);
  assign x3   = gmul(x2, a);
  assign x6   = gmul(x3, x3);
  assign x7   = gmul(x6, a);
  assign x14  = gmul(x7, x7);
  assign x15  = gmul(x14, a);
  assign x30  = gmul(x15, x15);
  assign x31  = gmul(x30, a);
  assign x62  = gmul(x31, x31);
  assign x63  = gmul(x62, a);
  assign x126 = gmul(x63, x63);
  assign x127 = gmul(x126, a);
  assign inv  = gmul(x127, x127);

  assign y = inv
           ^ {inv[6:0], inv[7]}
           ^ {inv[5:0], inv[7:6]}
           ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]}
           ^ 8'h63;
endmodule

module aes_dec_key_prep #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_v_i,
  input  logic [127:0] in_data_i,
  input  logic [127:0] in_key_i,
  output logic         ready_o,
  output logic         out_v_o,
  output logic [127:0] out_data_o,
  output logic [127:0] out_key_o,
  input  logic         dec_res_v_i
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic [127:0] data_q;
  logic [127:0] work_key;
  logic [127:0] cache_key;
  logic         cache_v;
  logic [7:0]   rcon;
  logic [3:0]   cnt;

  logic         hit;
  logic         last;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot, sub, t;
  logic [31:0]  n0, n1, n2, n3;
  logic [7:0]   rcon_nxt;

  assign hit  = cache_v && (in_key_i == cache_key);
  assign last = (cnt == 4'(NR - 1));

  assign w0 = work_key[127:96];
  assign w1 = work_key[95:64];
  assign w2 = work_key[63:32];
  assign w3 = work_key[31:0];

  assign rot = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .a (rot[8*g +: 8]),
      .y (sub[8*g +: 8])
    );
  end

  assign t  = sub ^ {rcon, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign rcon_nxt = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (in_v_i) state_d = hit ? S_ISSUE : S_EXPAND;
      S_EXPAND: if (last) state_d = S_ISSUE;
      S_ISSUE:  state_d = S_WAIT;
      S_WAIT:   if (dec_res_v_i) state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      work_key  <= '0;
      cache_key <= '0;
      cache_v   <= 1'b0;
      rcon      <= 8'h01;
      cnt       <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: begin
          if (in_v_i) begin
            data_q <= in_data_i;
            if (!hit) begin
              work_key  <= in_key_i;
              cache_key <= in_key_i;
              cache_v   <= 1'b0;
              rcon      <= 8'h01;
              cnt       <= '0;
            end
          end
        end
        S_EXPAND: begin
          work_key <= {n0, n1, n2, n3};
          rcon     <= rcon_nxt;
          cnt      <= cnt + 4'd1;
          if (last) cache_v <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // work_key keeps the round-10 key after expansion, so hits reuse it
  assign ready_o    = (state_q == S_IDLE);
  assign out_v_o    = (state_q == S_ISSUE);
  assign out_data_o = data_q;
  assign out_key_o  = work_key;
endmodule

// File: tb/tb_aes_dec_key_prep.sv
// Directed bench for aes_dec_key_prep: FIPS-197 keys, cache hits,
// held inputs, mid-expansion reset and alternating keys.
module tb_aes_dec_key_prep;
  logic         clk;
  logic         reset;
  logic         in_v_i;
  logic [127:0] in_data_i;
  logic [127:0] in_key_i;
  logic         ready_o;
  logic         out_v_o;
  logic [127:0] out_data_o;
  logic [127:0] out_key_o;
  logic         dec_res_v_i;

  int n_cmp;
  int n_bad;

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] R_C1  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] D_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R_A   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R1_A  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] D_A   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] D_H   = 128'h3243f6a8885a308d313198a2e0370734;

  aes_dec_key_prep #(.NR(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_v_i      (in_v_i),
    .in_data_i   (in_data_i),
    .in_key_i    (in_key_i),
    .ready_o     (ready_o),
    .out_v_o     (out_v_o),
    .out_data_o  (out_data_o),
    .out_key_o   (out_key_o),
    .dec_res_v_i (dec_res_v_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drive one accepted input; returns at the negedge after the accept edge
  task automatic accept(input logic [127:0] d, input logic [127:0] k);
    in_v_i    = 1'b1;
    in_data_i = d;
    in_key_i  = k;
    @(negedge clk);
    in_v_i = 1'b0;
  endtask

  // lat = cycle index of out_v_o after accept, or -1 on timeout
  task automatic wait_pulse(input int k0, output int lat);
    lat = -1;
    for (int k = k0; k <= 40; k++) begin
      if (out_v_o) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic dec_done();
    @(negedge clk);
    dec_res_v_i = 1'b1;
    @(negedge clk);
    dec_res_v_i = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: got %b want 1", ready_o);
    end
    n_cmp++;
    if (out_v_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_out_v: got %b want 0", out_v_o);
    end
    n_cmp++;
    if (out_data_o !== 128'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0", out_data_o);
    end
    n_cmp++;
    if (out_key_o !== 128'h0) begin
      n_bad++;
      $display("FAIL reset_key: got %h want 0", out_key_o);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_miss_c1();
    int lat;
    accept(D_C1, K_C1);
    n_cmp++;
    if (ready_o !== 1'b0) begin
      n_bad++;
      $display("FAIL c1_ready_fall: got %b want 0", ready_o);
    end
    wait_pulse(1, lat);
    n_cmp++;
    if (lat != 11) begin
      n_bad++;
      $display("FAIL c1_latency: got %0d want 11", lat);
    end
    n_cmp++;
    if (out_key_o !== R_C1) begin
      n_bad++;
      $display("FAIL c1_key: got %h want %h", out_key_o, R_C1);
    end
    n_cmp++;
    if (out_data_o !== D_C1) begin
      n_bad++;
      $display("FAIL c1_data: got %h want %h", out_data_o, D_C1);
    end
    @(negedge clk);
    n_cmp++;
    if (ready_o !== 1'b0 || out_v_o !== 1'b0) begin
      n_bad++;
      $display("FAIL c1_wait: got ready=%b v=%b want 0/0", ready_o, out_v_o);
    end
    dec_res_v_i = 1'b1;
    @(negedge clk);
    dec_res_v_i = 1'b0;
  endtask

  task automatic test_round1();
    int lat;
    accept(D_A, K_A);
    n_cmp++;
    if (out_key_o !== K_A) begin
      n_bad++;
      $display("FAIL a_load: got %h want %h", out_key_o, K_A);
    end
    @(negedge clk);
    n_cmp++;
    if (out_key_o !== R1_A) begin
      n_bad++;
      $display("FAIL a_round1: got %h want %h", out_key_o, R1_A);
    end
    wait_pulse(2, lat);
    n_cmp++;
    if (lat != 11) begin
      n_bad++;
      $display("FAIL a_latency: got %0d want 11", lat);
    end
    n_cmp++;
    if (out_key_o !== R_A) begin
      n_bad++;
      $display("FAIL a_key: got %h want %h", out_key_o, R_A);
    end
    dec_done();
  endtask

  task automatic test_hit();
    int lat;
    accept(D_H, K_A);
    wait_pulse(1, lat);
    n_cmp++;
    if (lat != 1) begin
      n_bad++;
      $display("FAIL hit_latency: got %0d want 1", lat);
    end
    n_cmp++;
    if (out_key_o !== R_A) begin
      n_bad++;
      $display("FAIL hit_key: got %h want %h", out_key_o, R_A);
    end
    n_cmp++;
    if (out_data_o !== D_H) begin
      n_bad++;
      $display("FAIL hit_data: got %h want %h", out_data_o, D_H);
    end
    dec_done();
  endtask

  task automatic test_hold();
    int pulses;
    int first;
    pulses = 0;
    first = -1;
    in_v_i    = 1'b1;
    in_data_i = D_C1;
    in_key_i  = K_C1;
    @(negedge clk);
    for (int k = 1; k <= 20; k++) begin
      if (out_v_o) begin
        pulses++;
        if (first < 0) first = k;
      end
      dec_res_v_i = (k == 3);
      @(negedge clk);
    end
    dec_res_v_i = 1'b0;
    n_cmp++;
    if (pulses != 1) begin
      n_bad++;
      $display("FAIL hold_pulses: got %0d want 1", pulses);
    end
    n_cmp++;
    if (first != 11) begin
      n_bad++;
      $display("FAIL hold_latency: got %0d want 11", first);
    end
    n_cmp++;
    if (ready_o !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_wait_ready: got %b want 0", ready_o);
    end
    dec_res_v_i = 1'b1;
    @(negedge clk);
    dec_res_v_i = 1'b0;
    n_cmp++;
    if (ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_ready_rise: got %b want 1", ready_o);
    end
    @(negedge clk);
    n_cmp++;
    if (out_v_o !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_reaccept: got %b want 1", out_v_o);
    end
    n_cmp++;
    if (out_key_o !== R_C1) begin
      n_bad++;
      $display("FAIL hold_key: got %h want %h", out_key_o, R_C1);
    end
    in_v_i = 1'b0;
    dec_done();
  endtask

  task automatic test_reset_mid();
    int lat;
    accept(D_A, K_A);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (ready_o !== 1'b1 || out_v_o !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_ctrl: got ready=%b v=%b want 1/0", ready_o, out_v_o);
    end
    n_cmp++;
    if (out_key_o !== 128'h0) begin
      n_bad++;
      $display("FAIL mid_key: got %h want 0", out_key_o);
    end
    n_cmp++;
    if (out_data_o !== 128'h0) begin
      n_bad++;
      $display("FAIL mid_data: got %h want 0", out_data_o);
    end
    @(negedge clk);
    reset = 1'b0;
    dec_res_v_i = 1'b1;
    @(negedge clk);
    dec_res_v_i = 1'b0;
    n_cmp++;
    if (ready_o !== 1'b1 || out_v_o !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_stray_res: got ready=%b v=%b want 1/0", ready_o, out_v_o);
    end
    accept(D_A, K_A);
    wait_pulse(1, lat);
    n_cmp++;
    if (lat != 11) begin
      n_bad++;
      $display("FAIL mid_latency: got %0d want 11", lat);
    end
    n_cmp++;
    if (out_key_o !== R_A) begin
      n_bad++;
      $display("FAIL mid_key_after: got %h want %h", out_key_o, R_A);
    end
    dec_done();
  endtask

  task automatic test_alternate();
    logic [127:0] ks [3];
    logic [127:0] rs [3];
    logic [127:0] ds [3];
    int lat;
    ks[0] = K_C1; rs[0] = R_C1; ds[0] = D_C1;
    ks[1] = K_A;  rs[1] = R_A;  ds[1] = D_A;
    ks[2] = K_C1; rs[2] = R_C1; ds[2] = D_H;
    for (int i = 0; i < 3; i++) begin
      accept(ds[i], ks[i]);
      wait_pulse(1, lat);
      n_cmp++;
      if (lat != 11) begin
        n_bad++;
        $display("FAIL alt%0d_latency: got %0d want 11", i, lat);
      end
      n_cmp++;
      if (out_key_o !== rs[i] || out_data_o !== ds[i]) begin
        n_bad++;
        $display("FAIL alt%0d_out: got %h/%h want %h/%h",
                 i, out_key_o, out_data_o, rs[i], ds[i]);
      end
      dec_done();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset       = 1'b1;
    in_v_i      = 1'b0;
    in_data_i   = '0;
    in_key_i    = '0;
    dec_res_v_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_miss_c1();
    test_round1();
    test_hit();
    test_hold();
    test_reset_mid();
    test_alternate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
